// File: rtl/ws2812_frame_feeder.sv
`timescale 1ns/1ps
// Feeds 8x8 frame buffer pixels to the WS2812B encoder in chain order, brightness-scaled, GRB packed.
// Latency: first word 3 cycles after frame_start; each following word is valid the cycle after tx_done.
// Backpressure: advances only on encoder tx_done; frame starts held off by the frame-rate timer.
module ws2812_frame_feeder #(
    parameter int FRAME_CYCLES = 1_666_667,
    parameter int PIX_NUM      = 64,
    parameter int MATRIX_W     = 8,
    parameter int SERPENTINE   = 1
) (
    input  logic        sys_clk,
    input  logic        sys_rst,
    input  logic [2:0]  brightness,
    output logic [5:0]  fb_rd_addr,
    input  logic [23:0] fb_rd_data,
    input  logic        tx_done,
    output logic [23:0] rgb_data,
    output logic        tx_24x64_done,
    output logic        frame_start,
    output logic        frame_busy
);

    localparam logic [1:0]  ST_GAP    = 2'd0;
    localparam logic [1:0]  ST_LOAD   = 2'd1;
    localparam logic [1:0]  ST_SEND   = 2'd2;
    localparam logic [20:0] TMR_MAX   = 21'(FRAME_CYCLES - 1);
    localparam logic [5:0]  LAST_IDX  = 6'(PIX_NUM - 1);
    localparam logic [5:0]  PREF_LAST = 6'(PIX_NUM - 2);

    typedef struct packed {
        logic [7:0] r;
        logic [7:0] g;
        logic [7:0] b;
    } pix_t;

    logic [1:0]  state;
    logic [20:0] frame_tmr;
    logic [5:0]  idx;
    logic [2:0]  bright_lat;
    logic [23:0] nxt_dat;
    logic        iss_vld;
    logic        iss_nxt;
    logic        rd_vld;
    logic        rd_nxt;
    pix_t        fb_pix;
    logic [23:0] scaled_dat;

    function automatic logic [5:0] chain_to_addr(input logic [5:0] i);
        int row;
        int col;
        row = int'(i) / MATRIX_W;
        col = int'(i) % MATRIX_W;
        if (SERPENTINE != 0 && (row % 2) == 1)
            col = MATRIX_W - 1 - col;
        return 6'(row * MATRIX_W + col);
    endfunction

    function automatic logic [7:0] scale(input logic [7:0] c, input logic [2:0] b);
        logic [10:0] prod;
        prod = {3'b000, c} * ({8'h00, b} + 11'd1);
        return prod[10:3];
    endfunction

    assign fb_pix     = fb_rd_data;
    assign scaled_dat = {scale(fb_pix.g, bright_lat), scale(fb_pix.r, bright_lat),
                         scale(fb_pix.b, bright_lat)};

    // iss_* marks the cycle an address is on fb_rd_addr; rd_* marks the following data cycle.
    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            state         <= ST_GAP;
            frame_tmr     <= '0;
            idx           <= '0;
            bright_lat    <= '0;
            nxt_dat       <= '0;
            iss_vld       <= 1'b0;
            iss_nxt       <= 1'b0;
            rd_vld        <= 1'b0;
            rd_nxt        <= 1'b0;
            fb_rd_addr    <= '0;
            rgb_data      <= '0;
            tx_24x64_done <= 1'b1;
            frame_start   <= 1'b0;
            frame_busy    <= 1'b0;
        end else begin
            frame_start <= 1'b0;
            iss_vld     <= 1'b0;
            rd_vld      <= iss_vld;
            rd_nxt      <= iss_nxt;
            if (frame_tmr != TMR_MAX)
                frame_tmr <= frame_tmr + 21'd1;
            if (rd_vld) begin
                if (rd_nxt)
                    nxt_dat <= scaled_dat;
                else
                    rgb_data <= scaled_dat;
            end
            case (state)
                ST_GAP: begin
                    if (frame_tmr == TMR_MAX) begin
                        frame_tmr   <= '0;
                        frame_start <= 1'b1;
                        bright_lat  <= brightness;
                        frame_busy  <= 1'b1;
                        fb_rd_addr  <= chain_to_addr(6'd0);
                        iss_vld     <= 1'b1;
                        iss_nxt     <= 1'b0;
                        state       <= ST_LOAD;
                    end
                end
                ST_LOAD: begin
                    if (iss_vld && !iss_nxt) begin
                        fb_rd_addr <= chain_to_addr(6'd1);
                        iss_vld    <= 1'b1;
                        iss_nxt    <= 1'b1;
                    end
                    if (rd_vld && rd_nxt) begin
                        tx_24x64_done <= 1'b0;
                        state         <= ST_SEND;
                    end
                end
                ST_SEND: begin
                    if (tx_done) begin
                        if (idx == LAST_IDX) begin
                            tx_24x64_done <= 1'b1;
                            frame_busy    <= 1'b0;
                            idx           <= '0;
                            state         <= ST_GAP;
                        end else begin
                            rgb_data <= nxt_dat;
                            idx      <= idx + 6'd1;
                            if (idx < PREF_LAST) begin
                                fb_rd_addr <= chain_to_addr(idx + 6'd2);
                                iss_vld    <= 1'b1;
                                iss_nxt    <= 1'b1;
                            end
                        end
                    end
                end
                default: state <= ST_GAP;
            endcase
        end
    end

endmodule
